// File: rtl/reorder_buffer.sv
// In-order retirement queue: dispatch allocates at the tail, three pipelines mark entries done,
// and the oldest done entry retires through a registered commit port one per cycle.
module reorder_buffer #(
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned IDX_W     = 5,
  parameter int unsigned PR_ADDR_W = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   alloc_valid,
  output logic                   alloc_ready,
  output logic [IDX_W-1:0]       alloc_idx,
  input  logic [2*PR_ADDR_W-1:0] alloc_free_regs,
  input  logic [1:0]             alloc_free_mask,
  input  logic                   comp_arith_valid,
  input  logic [IDX_W-1:0]       comp_arith_idx,
  input  logic                   comp_mem_valid,
  input  logic [IDX_W-1:0]       comp_mem_idx,
  input  logic                   comp_term_valid,
  input  logic [IDX_W-1:0]       comp_term_idx,
  output logic                   commit_valid,
  input  logic                   commit_ready,
  output logic [IDX_W-1:0]       commit_idx,
  output logic [2*PR_ADDR_W-1:0] commit_free_regs,
  output logic [1:0]             commit_free_mask,
  output logic [IDX_W:0]         count,
  output logic                   comp_err
);

  logic [IDX_W:0]         head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]       valid_q, valid_d, done_q, done_d;
  logic [2*PR_ADDR_W-1:0] regs_q [DEPTH];
  logic [1:0]             mask_q [DEPTH];

  logic                   commit_valid_q, commit_valid_d;
  logic [IDX_W-1:0]       commit_idx_q, commit_idx_d;
  logic [2*PR_ADDR_W-1:0] commit_regs_q, commit_regs_d;
  logic [1:0]             commit_mask_q, commit_mask_d;
  logic                   comp_err_q, comp_err_d;

  logic [IDX_W-1:0] head_lo, tail_lo;
  logic             full, alloc_fire, load_en, commit_fire;
  logic [2:0]       comp_v;
  logic [IDX_W-1:0] comp_i [3];
  logic [DEPTH-1:0] comp_set;
  logic             comp_bad;

  assign head_lo = head_q[IDX_W-1:0];
  assign tail_lo = tail_q[IDX_W-1:0];

  // Full when low bits match but the wrap bits differ.
  assign full        = (head_lo == tail_lo) && (head_q[IDX_W] != tail_q[IDX_W]);
  assign alloc_ready = !full;
  assign alloc_idx   = tail_lo;
  assign count       = tail_q - head_q;
  assign alloc_fire  = alloc_valid && alloc_ready;

  assign comp_v    = {comp_term_valid, comp_mem_valid, comp_arith_valid};
  assign comp_i[0] = comp_arith_idx;
  assign comp_i[1] = comp_mem_idx;
  assign comp_i[2] = comp_term_idx;

  always_comb begin
    comp_set = '0;
    comp_bad = 1'b0;
    for (int p = 0; p < 3; p++) begin
      if (comp_v[p]) begin
        if (valid_q[comp_i[p]]) comp_set[comp_i[p]] = 1'b1;
        else                    comp_bad = 1'b1;
      end
    end
  end

  // Eligibility uses pre-edge done, so a completion takes one extra cycle to reach commit.
  assign load_en     = !commit_valid_q || commit_ready;
  assign commit_fire = load_en && valid_q[head_lo] && done_q[head_lo];

  always_comb begin
    head_d         = head_q;
    tail_d         = tail_q;
    valid_d        = valid_q;
    done_d         = done_q | comp_set;
    commit_valid_d = commit_valid_q;
    commit_idx_d   = commit_idx_q;
    commit_regs_d  = commit_regs_q;
    commit_mask_d  = commit_mask_q;
    comp_err_d     = comp_err_q | comp_bad;

    if (commit_fire) begin
      valid_d[head_lo] = 1'b0;
      head_d           = head_q + 1'b1;
      commit_valid_d   = 1'b1;
      commit_idx_d     = head_lo;
      commit_regs_d    = regs_q[head_lo];
      commit_mask_d    = mask_q[head_lo];
    end else if (load_en) begin
      commit_valid_d = 1'b0;
    end

    if (alloc_fire) begin
      valid_d[tail_lo] = 1'b1;
      done_d[tail_lo]  = 1'b0;
      tail_d           = tail_q + 1'b1;
    end

    if (flush) begin
      head_d         = '0;
      tail_d         = '0;
      valid_d        = '0;
      done_d         = '0;
      commit_valid_d = 1'b0;
      comp_err_d     = comp_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      valid_q        <= '0;
      done_q         <= '0;
      commit_valid_q <= 1'b0;
      commit_idx_q   <= '0;
      commit_regs_q  <= '0;
      commit_mask_q  <= '0;
      comp_err_q     <= 1'b0;
    end else begin
      head_q         <= head_d;
      tail_q         <= tail_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      commit_valid_q <= commit_valid_d;
      commit_idx_q   <= commit_idx_d;
      commit_regs_q  <= commit_regs_d;
      commit_mask_q  <= commit_mask_d;
      comp_err_q     <= comp_err_d;
    end
  end

  // Payload is only meaningful while the entry is valid, so it needs no reset.
  always_ff @(posedge clk) begin
    if (alloc_fire && !flush) begin
      regs_q[tail_lo] <= alloc_free_regs;
      mask_q[tail_lo] <= alloc_free_mask;
    end
  end

  assign commit_valid     = commit_valid_q;
  assign commit_idx       = commit_idx_q;
  assign commit_free_regs = commit_regs_q;
  assign commit_free_mask = commit_mask_q;
  assign comp_err         = comp_err_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, corner-case sequences and random traffic,
// all checked against a queue-based model of the retirement rules.
module tb_reorder_buffer;

  localparam int DEPTH = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       flush = 1'b0;
  logic       alloc_valid = 1'b0;
  logic       commit_ready = 1'b1;
  logic [9:0] alloc_free_regs = '0;
  logic [1:0] alloc_free_mask = '0;
  logic       ca_v = 1'b0, cm_v = 1'b0, ct_v = 1'b0;
  logic [4:0] ca_i = '0, cm_i = '0, ct_i = '0;

  logic       alloc_ready, commit_valid, comp_err;
  logic [4:0] alloc_idx, commit_idx;
  logic [9:0] commit_free_regs;
  logic [1:0] commit_free_mask;
  logic [5:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  reorder_buffer #(.DEPTH(32), .IDX_W(5), .PR_ADDR_W(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .alloc_valid      (alloc_valid),
    .alloc_ready      (alloc_ready),
    .alloc_idx        (alloc_idx),
    .alloc_free_regs  (alloc_free_regs),
    .alloc_free_mask  (alloc_free_mask),
    .comp_arith_valid (ca_v),
    .comp_arith_idx   (ca_i),
    .comp_mem_valid   (cm_v),
    .comp_mem_idx     (cm_i),
    .comp_term_valid  (ct_v),
    .comp_term_idx    (ct_i),
    .commit_valid     (commit_valid),
    .commit_ready     (commit_ready),
    .commit_idx       (commit_idx),
    .commit_free_regs (commit_free_regs),
    .commit_free_mask (commit_free_mask),
    .count            (count),
    .comp_err         (comp_err)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of live entries plus the commit holding register.
  typedef struct {
    int       idx;
    bit [9:0] regs;
    bit [1:0] mask;
    bit       done;
  } ment_t;

  ment_t    mq[$];
  int       m_tail;
  bit       m_cv, m_err;
  int       m_cidx;
  bit [9:0] m_cregs;
  bit [1:0] m_cmask;

  task automatic model_reset();
    mq.delete();
    m_tail = 0; m_cv = 0; m_err = 0; m_cidx = 0; m_cregs = '0; m_cmask = '0;
  endtask

  task automatic model_complete(input int idx);
    bit found;
    found = 0;
    for (int i = 0; i < mq.size(); i++)
      if (mq[i].idx == idx) begin mq[i].done = 1; found = 1; end
    if (!found) m_err = 1;
  endtask

  task automatic model_edge();
    int    pre_size;
    bit    elig;
    ment_t e;
    if (flush) begin
      mq.delete(); m_tail = 0; m_cv = 0;
      return;
    end
    pre_size = mq.size();
    elig = (pre_size > 0) && mq[0].done;
    if (ca_v) model_complete(int'(ca_i));
    if (cm_v) model_complete(int'(cm_i));
    if (ct_v) model_complete(int'(ct_i));
    if (!m_cv || commit_ready) begin
      if (elig) begin
        e = mq.pop_front();
        m_cv = 1; m_cidx = e.idx; m_cregs = e.regs; m_cmask = e.mask;
      end else begin
        m_cv = 0;
      end
    end
    if (alloc_valid && pre_size < DEPTH) begin
      e.idx = m_tail % DEPTH; e.regs = alloc_free_regs; e.mask = alloc_free_mask; e.done = 0;
      mq.push_back(e);
      m_tail++;
    end
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("alloc_ready", int'(alloc_ready), int'(mq.size() < DEPTH));
    chk("alloc_idx", int'(alloc_idx), m_tail % DEPTH);
    chk("count", int'(count), mq.size());
    chk("commit_valid", int'(commit_valid), int'(m_cv));
    if (m_cv) begin
      chk("commit_idx", int'(commit_idx), m_cidx);
      chk("commit_free_regs", int'(commit_free_regs), int'(m_cregs));
      chk("commit_free_mask", int'(commit_free_mask), int'(m_cmask));
    end
    chk("comp_err", int'(comp_err), int'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic idle();
    alloc_valid = 0; ca_v = 0; cm_v = 0; ct_v = 0; flush = 0; commit_ready = 1;
  endtask

  task automatic set_alloc_rand();
    alloc_valid = 1;
    alloc_free_regs = 10'($urandom);
    alloc_free_mask = 2'($urandom);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, ".commit_valid"}, int'(commit_valid), 0);
    chk({nm, ".commit_idx"}, int'(commit_idx), 0);
    chk({nm, ".commit_free_regs"}, int'(commit_free_regs), 0);
    chk({nm, ".commit_free_mask"}, int'(commit_free_mask), 0);
    chk({nm, ".count"}, int'(count), 0);
    chk({nm, ".alloc_ready"}, int'(alloc_ready), 1);
    chk({nm, ".alloc_idx"}, int'(alloc_idx), 0);
    chk({nm, ".comp_err"}, int'(comp_err), 0);
  endtask

  function automatic logic [4:0] pick();
    if (mq.size() > 0 && ($urandom % 5) != 0)
      return 5'(mq[$urandom_range(mq.size() - 1, 0)].idx);
    return 5'($urandom);
  endfunction

  typedef struct {
    bit       av;
    bit [9:0] regs;
    bit [1:0] mask;
    bit       a_v; int a_i;
    bit       m_v; int m_i;
    bit       t_v; int t_i;
    int       e_count;
    int       e_aidx;
    bit       e_cv;
    int       e_cidx;
    bit [9:0] e_regs;
    bit [1:0] e_mask;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1, 10'h021, 2'b11, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 10'h000, 2'b00};
    tbl[1] = '{1, 10'h043, 2'b01, 0, 0, 0, 0, 0, 0, 2, 2, 0, 0, 10'h000, 2'b00};
    tbl[2] = '{1, 10'h065, 2'b10, 0, 0, 0, 0, 0, 0, 3, 3, 0, 0, 10'h000, 2'b00};
    tbl[3] = '{0, 10'h000, 2'b00, 1, 2, 0, 0, 0, 0, 3, 3, 0, 0, 10'h000, 2'b00};
    tbl[4] = '{0, 10'h000, 2'b00, 0, 0, 1, 1, 0, 0, 3, 3, 0, 0, 10'h000, 2'b00};
    tbl[5] = '{0, 10'h000, 2'b00, 0, 0, 0, 0, 1, 0, 3, 3, 0, 0, 10'h000, 2'b00};
    tbl[6] = '{0, 10'h000, 2'b00, 0, 0, 0, 0, 0, 0, 2, 3, 1, 0, 10'h021, 2'b11};
    tbl[7] = '{0, 10'h000, 2'b00, 0, 0, 0, 0, 0, 0, 1, 3, 1, 1, 10'h043, 2'b01};
    tbl[8] = '{0, 10'h000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 1, 2, 10'h065, 2'b10};
    tbl[9] = '{0, 10'h000, 2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 10'h000, 2'b00};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 0;

    // Directed table: three allocations completed youngest-first.
    for (int v = 0; v < 10; v++) begin
      idle();
      alloc_valid = tbl[v].av; alloc_free_regs = tbl[v].regs; alloc_free_mask = tbl[v].mask;
      ca_v = tbl[v].a_v; ca_i = 5'(tbl[v].a_i);
      cm_v = tbl[v].m_v; cm_i = 5'(tbl[v].m_i);
      ct_v = tbl[v].t_v; ct_i = 5'(tbl[v].t_i);
      step();
      chk("tbl.count", int'(count), tbl[v].e_count);
      chk("tbl.alloc_idx", int'(alloc_idx), tbl[v].e_aidx);
      chk("tbl.commit_valid", int'(commit_valid), int'(tbl[v].e_cv));
      if (tbl[v].e_cv) begin
        chk("tbl.commit_idx", int'(commit_idx), tbl[v].e_cidx);
        chk("tbl.commit_free_regs", int'(commit_free_regs), int'(tbl[v].e_regs));
        chk("tbl.commit_free_mask", int'(commit_free_mask), int'(tbl[v].e_mask));
      end
    end

    // Fill to DEPTH; an extra request must be ignored without overwriting entry 0.
    idle(); flush = 1; step();
    for (int i = 0; i < DEPTH; i++) begin idle(); set_alloc_rand(); step(); end
    chk("full.alloc_ready", int'(alloc_ready), 0);
    chk("full.count", int'(count), 32);
    idle(); alloc_valid = 1; alloc_free_regs = 10'h3ff; alloc_free_mask = 2'b11; step();
    chk("full.count_hold", int'(count), 32);
    chk("full.alloc_idx_hold", int'(alloc_idx), 0);
    idle(); ca_v = 1; ca_i = 5'd0; step();
    idle(); step();

    // Entries 0..4 done behind a stalled consumer, then index 5 named by all three ports.
    idle(); flush = 1; step();
    for (int i = 0; i < 8; i++) begin idle(); set_alloc_rand(); step(); end
    for (int k = 0; k < 5; k++) begin
      idle(); commit_ready = 0; ca_v = 1; ca_i = 5'(k); step();
    end
    idle(); commit_ready = 0; ca_v = 1; cm_v = 1; ct_v = 1; ca_i = 5'd5; cm_i = 5'd5; ct_i = 5'd5;
    step();
    chk("tri.hold_idx", int'(commit_idx), 0);
    chk("tri.comp_err", int'(comp_err), 0);
    for (int k = 1; k <= 5; k++) begin
      idle(); step();
      chk("tri.commit_valid", int'(commit_valid), 1);
      chk("tri.commit_idx", int'(commit_idx), k);
    end
    idle(); step();
    chk("tri.drained", int'(commit_valid), 0);
    chk("tri.comp_err_end", int'(comp_err), 0);

    // Backpressure with entry 7 in the holding register.
    idle(); flush = 1; step();
    for (int i = 0; i < 10; i++) begin idle(); set_alloc_rand(); step(); end
    for (int k = 0; k <= 8; k++) begin idle(); ca_v = 1; ca_i = 5'(k); step(); end
    chk("bp.commit_idx", int'(commit_idx), 7);
    chk("bp.count", int'(count), 2);
    for (int i = 0; i < 4; i++) begin
      idle(); commit_ready = 0; step();
      chk("bp.hold_valid", int'(commit_valid), 1);
      chk("bp.hold_idx", int'(commit_idx), 7);
      chk("bp.hold_count", int'(count), 2);
    end
    idle(); step();
    chk("bp.release_idx", int'(commit_idx), 8);
    chk("bp.release_valid", int'(commit_valid), 1);
    idle(); step();
    chk("bp.after_valid", int'(commit_valid), 0);

    // Completion of a non-allocated entry; stale state must not survive re-allocation.
    idle(); flush = 1; step();
    for (int i = 0; i < 10; i++) begin idle(); set_alloc_rand(); step(); end
    idle(); ca_v = 1; ca_i = 5'd20; step();
    chk("err.set", int'(comp_err), 1);
    idle(); flush = 1; step();
    chk("err.sticky", int'(comp_err), 1);
    chk("err.flush_count", int'(count), 0);
    for (int i = 0; i < 21; i++) begin idle(); set_alloc_rand(); step(); end
    for (int k = 0; k < 20; k++) begin idle(); cm_v = 1; cm_i = 5'(k); step(); end
    idle(); step();
    idle(); step();
    chk("err.entry20_not_done", int'(commit_valid), 0);
    chk("err.entry20_left", int'(count), 1);

    // Streaming through the wrap point, then async reset mid-commit.
    idle(); flush = 1; step();
    for (int n = 0; n <= 40; n++) begin
      idle();
      if (n < 40) begin
        chk("wrap.alloc_ready", int'(alloc_ready), 1);
        chk("wrap.alloc_idx", int'(alloc_idx), n % 32);
        set_alloc_rand();
      end
      if (n >= 1) begin ca_v = 1; ca_i = 5'((n - 1) % 32); end
      step();
    end
    chk("wrap.mid_commit", int'(commit_valid), 1);
    idle();
    rst = 1;
    #1;
    model_reset();
    check_reset_state("async_rst");
    @(posedge clk);
    #1;
    rst = 0;

    // Flush with a commit pending.
    for (int i = 0; i < 2; i++) begin idle(); set_alloc_rand(); step(); end
    idle(); ct_v = 1; ct_i = 5'd0; step();
    idle(); commit_ready = 0; step();
    chk("flush.pre_valid", int'(commit_valid), 1);
    idle(); flush = 1; set_alloc_rand(); ca_v = 1; ca_i = 5'd1; step();
    chk("flush.count", int'(count), 0);
    chk("flush.commit_valid", int'(commit_valid), 0);

    // Random traffic against the model.
    for (int c = 0; c < 1500; c++) begin
      idle();
      if (($urandom % 10) < 6) set_alloc_rand();
      commit_ready = ($urandom % 10) < 7;
      flush = ($urandom % 100) == 0;
      ca_v = ($urandom % 3) == 0; ca_i = pick();
      cm_v = ($urandom % 3) == 0; cm_i = pick();
      ct_v = ($urandom % 3) == 0; ct_i = pick();
      if (($urandom % 8) == 0) begin cm_i = ca_i; ct_i = ca_i; end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- In-order retirement queue that receives completion notifications from the middle end: the arith, mem and term pipelines each report a ROB entry index plus a valid strobe.
- Entries are allocated in program order by the rename/dispatch stage.
- Each entry is marked done when any completion port names it.
- The oldest done entry retires one per cycle. Retirement hands back the previous physical registers so the free list can reclaim them.

Parameters:
DEPTH, 32, number of ROB entries (power of two)
IDX_W, 5, log2(DEPTH); width of ROB entry index
PR_ADDR_W, 5, physical register address width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, asynchronous, active-high
flush  in  1  synchronous discard of all entries
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  entry available (count < DEPTH)
alloc_idx  out  IDX_W  index granted; equals tail pointer low bits
alloc_free_regs  in  2*PR_ADDR_W  {old flag preg, old dest preg} to free at commit
alloc_free_mask  in  2  per-field valid for alloc_free_regs
comp_arith_valid  in  1  arith completion strobe
comp_arith_idx  in  IDX_W  arith completed entry
comp_mem_valid  in  1  mem completion strobe
comp_mem_idx  in  IDX_W  mem completed entry
comp_term_valid  in  1  term completion strobe
comp_term_idx  in  IDX_W  term completed entry
commit_valid  out  1  retired entry presented (registered)
commit_ready  in  1  consumer accepts commit
commit_idx  out  IDX_W  retired entry index
commit_free_regs  out  2*PR_ADDR_W  pregs to return to free list
commit_free_mask  out  2  which commit_free_regs fields are valid
count  out  IDX_W+1  occupied entries
comp_err  out  1  sticky: completion named a non-allocated entry

Behaviour:
- State:
  - head and tail pointers, IDX_W+1 bits each; wrap modulo 2*DEPTH.
  - Per entry: valid bit, done bit, free_regs, free_mask.
  - Output holding register for the commit_* outputs.
- Empty: head == tail. Full: low bits equal and MSBs differ. count = tail - head.
- Reset (async): head = tail = 0, all valid/done = 0, commit_valid = 0, commit_idx/free_regs/free_mask = 0, comp_err = 0. Hence alloc_ready = 1 and count = 0 out of reset.
- alloc_ready is driven only from registered state. A commit in the same cycle does not open a slot while full.
- Allocation fire (alloc_valid && alloc_ready):
  - entry[tail] gets valid = 1, done = 0, and the free_regs/free_mask payload.
  - tail increments.
- Completion:
  - Each comp_*_valid with entry[idx].valid = 1 (pre-edge) sets done = 1.
  - Two or three ports naming the same index in one cycle are legal; the entry is simply done.
  - A completion naming an entry with valid = 0 is ignored and sets comp_err.
- Commit holding register loads when (!commit_valid || commit_ready) and entry[head] is valid and done (pre-edge done):
  - commit_valid = 1; commit_idx, commit_free_regs, commit_free_mask come from that entry.
  - entry[head].valid = 0 and head increments.
  - If the register frees but no entry is eligible, commit_valid goes to 0.
  - If commit_valid && !commit_ready, all commit_* outputs hold stable and head does not advance.
- Latency: a completion sampled at edge E0 gives commit_valid high after E1, provided the entry is at head and the holding register is free. Maximum throughput is one commit per cycle.
- In-order rule: a younger done entry never retires before an older not-done entry.
- Flush (synchronous, highest priority):
  - head = tail = 0, all valid/done = 0, commit_valid = 0.
  - Allocation and completions in the same cycle are dropped.
  - comp_err is unaffected.
- Simultaneous alloc and commit while neither full nor empty: both occur; count is unchanged.
- Wrap: indices roll from DEPTH-1 to 0 with no bubble.

Test Plan:
- Reset, then allocate 3 entries -> alloc_idx 0,1,2; count = 3. Complete entries 2, 1, then 0 on one cycle each -> commits 0,1,2 in consecutive cycles after 0 completes, each carrying its alloc_free_regs.
- Allocate 32 -> alloc_ready = 0 and count = 32. Next alloc_valid is ignored, tail is unchanged and no entry is overwritten.
- All three ports complete index 5 in one cycle, with entries 0..4 already done -> entries 0..5 commit one per cycle. comp_err stays 0.
- Hold commit_ready = 0 for 4 cycles with commit_valid = 1, commit_idx = 7 -> outputs stable and count unchanged; release -> idx 7 then idx 8 on consecutive cycles.
- Complete index 20 while only 0..9 are allocated -> comp_err = 1 (sticky through flush). Entry 20 is not marked done after a later allocation reaches it.
- Wrap and reset:
  - Allocate/commit 40 entries -> idx sequence 0..31,0..7; no stall at wrap.
  - Assert rst mid-commit -> all outputs immediately 0 and alloc_ready = 1.
  - flush -> count = 0 and commit_valid = 0 on the next cycle.
